// File: rtl/stim_pulse_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : stim_pulse_gen                                                  |
// | Turns a stimulation decision into a charge-balanced biphasic pulse train |
// | (cathodic, gap, anodic, inter-pulse interval) with abort and optional    |
// | post-train refractory lockout enabled by STIM_REFRACTORY_EN.             |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module stim_pulse_gen #(
  parameter int PHASE_CYC   = 100,
  parameter int GAP_CYC     = 20,
  parameter int IPI_CYC     = 880,
  parameter int N_PULSES    = 10,
  parameter int REFRACT_CYC = 100000,
  parameter int AMP_WIDTH   = 8,
  parameter int CNT_WIDTH   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stim_req,
  input  logic                 stim_abort,
  input  logic [AMP_WIDTH-1:0] amp_in,
  output logic                 stim_cath,
  output logic                 stim_anod,
  output logic [AMP_WIDTH-1:0] stim_amp,
  output logic                 busy,
  output logic                 train_done,
  output logic                 aborted
);

  localparam int c_pulse_w = (N_PULSES > 1) ? $clog2(N_PULSES) : 1;

  localparam logic [CNT_WIDTH-1:0] c_phase_last = CNT_WIDTH'(PHASE_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] c_gap_last   = CNT_WIDTH'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] c_ipi_last   = CNT_WIDTH'(IPI_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] c_refr_last  = CNT_WIDTH'(REFRACT_CYC - 1);
  localparam logic [c_pulse_w-1:0] c_pulse_last = c_pulse_w'(N_PULSES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CATH = 3'd1,
    S_GAP  = 3'd2,
    S_ANOD = 3'd3,
    S_IPI  = 3'd4,
    S_REFR = 3'd5
  } state_t;

`ifdef STIM_REFRACTORY_EN
  localparam state_t c_end_state = S_REFR;
`else
  localparam state_t c_end_state = S_IDLE;
`endif

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [c_pulse_w-1:0]   r_pulse;
  logic                   r_req_d;
  logic                   r_trig_pend;
  logic                   r_abort_pend;
  logic [AMP_WIDTH-1:0]   r_amp;
  logic                   r_cath;
  logic                   r_anod;
  logic [AMP_WIDTH-1:0]   r_amp_out;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_abt;

  state_t w_next;
  logic   w_done;
  logic   w_abt;
  logic   w_abort;
  logic   w_trig;
  logic   w_act_cur;
  logic   w_act_next;

  assign w_trig     = (r_state == S_IDLE) & stim_req & ~r_req_d & ~r_trig_pend;
  assign w_abort    = r_abort_pend | stim_abort;
  assign w_act_cur  = r_state inside {S_CATH, S_GAP, S_ANOD, S_IPI};
  assign w_act_next = w_next inside {S_CATH, S_GAP, S_ANOD, S_IPI};

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_abt  = 1'b0;
    case (r_state)
      S_IDLE: if (r_trig_pend) w_next = S_CATH;
      S_CATH: if (r_cnt == c_phase_last) w_next = (GAP_CYC == 0) ? S_ANOD : S_GAP;
      S_GAP:  if (r_cnt == c_gap_last) w_next = S_ANOD;
      S_ANOD: begin
        // Completion of the final pulse takes precedence over a pending abort.
        if (r_cnt == c_phase_last) begin
          if (r_pulse == c_pulse_last) begin
            w_done = 1'b1;
            w_next = c_end_state;
          end else if (w_abort) begin
            w_abt  = 1'b1;
            w_next = c_end_state;
          end else begin
            w_next = S_IPI;
          end
        end
      end
      S_IPI: begin
        if (w_abort) begin
          w_abt  = 1'b1;
          w_next = c_end_state;
        end else if (r_cnt == c_ipi_last) begin
          w_next = S_CATH;
        end
      end
      S_REFR:  if (r_cnt == c_refr_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pulse      <= '0;
      r_req_d      <= 1'b0;
      r_trig_pend  <= 1'b0;
      r_abort_pend <= 1'b0;
      r_amp        <= '0;
      r_cath       <= 1'b0;
      r_anod       <= 1'b0;
      r_amp_out    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abt        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_req_d      <= stim_req;
      r_trig_pend  <= w_trig;
      r_abort_pend <= w_act_cur & w_act_next & w_abort;

      if (w_trig) begin
        r_amp   <= amp_in;
        r_pulse <= '0;
      end else if (r_state == S_ANOD && w_next != S_ANOD) begin
        r_pulse <= r_pulse + c_pulse_w'(1);
      end

      if (w_trig || r_state == S_IDLE || w_next != r_state) r_cnt <= '0;
      else                                                  r_cnt <= r_cnt + 1'b1;

      // Outputs are decoded from the next state so they change with it.
      r_cath    <= (w_next == S_CATH);
      r_anod    <= (w_next == S_ANOD);
      r_amp_out <= (w_next == S_CATH || w_next == S_ANOD) ? r_amp : '0;
      r_busy    <= (w_next != S_IDLE);
      r_done    <= w_done;
      r_abt     <= w_abt;
    end
  end

  assign stim_cath  = r_cath;
  assign stim_anod  = r_anod;
  assign stim_amp   = r_amp_out;
  assign busy       = r_busy;
  assign train_done = r_done;
  assign aborted    = r_abt;

endmodule
`default_nettype wire

// File: tb/tb_stim_pulse_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_stim_pulse_gen                                               |
// | Bench for stim_pulse_gen: two instances (GAP_CYC=1 and GAP_CYC=0) vs a   |
// | timeline model of the pulse train; honours STIM_REFRACTORY_EN.           |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_stim_pulse_gen;

  localparam int P   = 3;
  localparam int IPI = 4;
  localparam int N   = 2;
  localparam int R   = 10;
`ifdef STIM_REFRACTORY_EN
  localparam bit REFR_EN = 1'b1;
`else
  localparam bit REFR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stim_req = 1'b0;
  logic       stim_abort = 1'b0;
  logic [7:0] amp_in = 8'h5A;

  logic       cath0, anod0, busy0, done0, abt0;
  logic [7:0] amp0;
  logic       cath1, anod1, busy1, done1, abt1;
  logic [7:0] amp1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  stim_pulse_gen #(.PHASE_CYC(P), .GAP_CYC(1), .IPI_CYC(IPI), .N_PULSES(N),
                   .REFRACT_CYC(R), .AMP_WIDTH(8), .CNT_WIDTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .stim_req(stim_req), .stim_abort(stim_abort), .amp_in(amp_in),
    .stim_cath(cath0), .stim_anod(anod0), .stim_amp(amp0), .busy(busy0),
    .train_done(done0), .aborted(abt0));

  stim_pulse_gen #(.PHASE_CYC(P), .GAP_CYC(0), .IPI_CYC(IPI), .N_PULSES(N),
                   .REFRACT_CYC(R), .AMP_WIDTH(8), .CNT_WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .stim_req(stim_req), .stim_abort(stim_abort), .amp_in(amp_in),
    .stim_cath(cath1), .stim_anod(anod1), .stim_amp(amp1), .busy(busy1),
    .train_done(done1), .aborted(abt1));

  // Model: each train is a start cycle t0 and an end cycle (first post-train cycle).
  longint     cyc = 0;
  bit         m_has [2];
  longint     m_t0  [2];
  longint     m_end [2];
  bit         m_abt [2];
  logic [7:0] m_amp [2];
  bit         m_reqd = 1'b0;
  longint     mk, moff, mep, mph, mper;

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit idle_at(input int i, input longint c);
    return !m_has[i] || c < m_t0[i] || c >= m_end[i] + (REFR_EN ? R : 0);
  endfunction

  function automatic logic [12:0] model_out(input int i, input longint c);
    longint     off, ph, per;
    logic       ca, an, bu, dn, ab;
    logic [7:0] am;
    ph  = 2 * P + gap_of(i);
    per = ph + IPI;
    ca = 1'b0; an = 1'b0; bu = 1'b0; dn = 1'b0; ab = 1'b0; am = 8'h00;
    if (m_has[i]) begin
      if (c >= m_t0[i] && c < m_end[i]) begin
        off = (c - m_t0[i]) % per;
        ca  = off < P;
        an  = off >= ph - P && off < ph;
      end
      bu = c >= m_t0[i] && c < m_end[i] + (REFR_EN ? R : 0);
      dn = c == m_end[i] && !m_abt[i];
      ab = c == m_end[i] && m_abt[i];
      if (ca || an) am = m_amp[i];
    end
    return {ca, an, bu, dn, ab, am};
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    mk  = cyc;
    if (rst) begin
      m_has[0] = 1'b0;
      m_has[1] = 1'b0;
      m_reqd   = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mph  = 2 * P + gap_of(i);
        mper = mph + IPI;
        if (m_has[i] && stim_abort && mk - 1 >= m_t0[i] && mk - 1 < m_end[i]) begin
          moff = mk - 1 - m_t0[i];
          if (moff % mper >= mph)   mep = mk;
          else if (moff / mper < N - 1) mep = m_t0[i] + (moff / mper) * mper + mph;
          else                      mep = m_end[i];
          if (mep < m_end[i]) begin
            m_end[i] = mep;
            m_abt[i] = 1'b1;
          end
        end
        if (stim_req && !m_reqd && idle_at(i, mk - 1)) begin
          m_has[i] = 1'b1;
          m_t0[i]  = mk + 1;
          m_end[i] = mk + 1 + N * mph + (N - 1) * IPI;
          m_abt[i] = 1'b0;
          m_amp[i] = amp_in;
        end
      end
      m_reqd = stim_req;
    end
  end

  logic [12:0] cmp_act, cmp_exp;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cmp_act = (i == 0) ? {cath0, anod0, busy0, done0, abt0, amp0}
                         : {cath1, anod1, busy1, done1, abt1, amp1};
      cmp_exp = model_out(i, cyc);
      n_checks++;
      if (cmp_act !== cmp_exp) begin
        n_err++;
        $display("FAIL model dut%0d cyc %0d: {cath,anod,busy,done,abt,amp} got %b expected %b",
                 i, cyc, cmp_act, cmp_exp);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  int c_cath [2], c_anod [2], c_done [2], c_abt [2], idx_done [2], c_amp5a;

  // Observe ncyc cycles; abort is raised for one cycle after negedge ab_at.
  task automatic run(input int ncyc, input int ab_at);
    for (int i = 0; i < 2; i++) begin
      c_cath[i] = 0; c_anod[i] = 0; c_done[i] = 0; c_abt[i] = 0; idx_done[i] = -1;
    end
    c_amp5a = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      c_cath[0] += int'(cath0); c_anod[0] += int'(anod0);
      c_done[0] += int'(done0); c_abt[0]  += int'(abt0);
      c_cath[1] += int'(cath1); c_anod[1] += int'(anod1);
      c_done[1] += int'(done1); c_abt[1]  += int'(abt1);
      if (done0 && idx_done[0] < 0) idx_done[0] = n;
      if (done1 && idx_done[1] < 0) idx_done[1] = n;
      if (amp0 == 8'h5A) c_amp5a++;
      stim_abort = (n == ab_at);
    end
    stim_abort = 1'b0;
  endtask

  task automatic rearm();
    stim_req = 1'b0;
    repeat (2) @(negedge clk);
    stim_req = 1'b1;
  endtask

  int cnt;
  bit seen;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cath0, anod0, busy0, done0, abt0, amp0,
                          cath1, anod1, busy1, done1, abt1, amp1}, 0);
    rst = 1'b0;
    @(negedge clk);

    stim_req = 1'b1;
    run(40, 0);
    chk("single_cath0", c_cath[0], 6);
    chk("single_anod0", c_anod[0], 6);
    chk("single_amp5a0", c_amp5a, 12);
    chk("single_done0", c_done[0], 1);
    chk("single_abt0", c_abt[0], 0);
    chk("single_done_idx0", idx_done[0], 20);
    chk("nogap_done_idx1", idx_done[1], 18);
    chk("nogap_anod1", c_anod[1], 6);

    rearm();
    run(30, 2);
    chk("abort_cath_cath0", c_cath[0], 3);
    chk("abort_cath_anod0", c_anod[0], 3);
    chk("abort_cath_abt0", c_abt[0], 1);
    chk("abort_cath_done0", c_done[0], 0);
    chk("abort_cath_abt1", c_abt[1], 1);

    rearm();
    run(30, 9);
    chk("abort_ipi_cath0", c_cath[0], 3);
    chk("abort_ipi_abt0", c_abt[0], 1);
    chk("abort_ipi_done0", c_done[0], 0);
    chk("abort_ipi_cath1", c_cath[1], 3);

    rearm();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_anod", {cath0, anod0, busy0, done0, abt0, amp0,
                           cath1, anod1, busy1, done1, abt1, amp1}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_edge1_cath0", cath0, 0);
    @(negedge clk);
    chk("restart_edge2_cath0", cath0, 1);
    chk("restart_edge2_cath1", cath1, 1);
    repeat (40) @(negedge clk);

    rearm();
    repeat (3) @(negedge clk);
    stim_req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = done0;
    end
    chk("wait_train_done", seen, 1);
`ifdef STIM_REFRACTORY_EN
    cnt = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      cnt += int'(cath0);
      if (j == 4)  stim_req = 1'b1;
      if (j == 6)  stim_req = 1'b0;
      if (j == 10) stim_req = 1'b1;
    end
    chk("refr_retrigger_ignored", cnt, 0);
`else
    stim_req = 1'b1;
`endif
    cnt = 0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      cnt += int'(cath0);
    end
    chk("retrigger_after_done", (cnt > 0) ? 1 : 0, 1);
    repeat (40) @(negedge clk);

    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) stim_req = ~stim_req;
      stim_abort = ($urandom_range(0, 39) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      amp_in     = 8'($urandom);
    end
    rst = 1'b0;
    stim_abort = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stim_pulse_gen.md
# stim_pulse_gen

Consumes the seizure-detection controller's `stimulation` decision and turns it into a charge-balanced biphasic stimulation pulse train for the electrode driver. Each trigger produces N_PULSES pulses:
- cathodic phase
- interphase gap
- anodic phase
- inter-pulse interval

An optional refractory lockout follows the train. The block sits between the majority-vote controller and the analog stimulator front end.

## Interface
Parameters:
- PHASE_CYC, 100: cycles per cathodic and per anodic phase (≥1).
- GAP_CYC, 20: interphase gap cycles (0 allowed = no gap).
- IPI_CYC, 880: inter-pulse interval cycles (≥1).
- N_PULSES, 10: pulses per train (≥1).
- REFRACT_CYC, 100000: post-train lockout cycles (≥1, used only with STIM_REFRACTORY_EN).
- AMP_WIDTH, 8: amplitude code width.
- CNT_WIDTH, 20: phase/interval counter width; every *_CYC must fit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- stim_req  in  1  level decision from controller; rising edge triggers.
- stim_abort  in  1  request to stop the train at the next pulse boundary.
- amp_in  in  AMP_WIDTH  amplitude code, latched at trigger.
- stim_cath  out  1  cathodic phase active.
- stim_anod  out  1  anodic phase active.
- stim_amp  out  AMP_WIDTH  latched amplitude during either phase, else 0.
- busy  out  1  high in any state other than IDLE.
- train_done  out  1  one-cycle pulse on normal train completion.
- aborted  out  1  one-cycle pulse when a train ends via abort.

## Operation
- States: IDLE, CATH, GAP, ANOD, IPI, REFR. All outputs are registered. Decode is `stim_cath` = CATH and `stim_anod` = ANOD.
- `req_d` is the registered `stim_req`. A trigger is `stim_req` & ~`req_d` while in IDLE. On a trigger:
  - latch `amp_in`
  - clear the cycle counter and pulse counter
  - go to CATH
- Triggers outside IDLE are dropped, not queued. Holding `stim_req` high never retriggers; it must fall and rise again.
- CATH lasts PHASE_CYC cycles.
- After CATH: go to GAP, or directly to ANOD if GAP_CYC=0.
- GAP lasts GAP_CYC cycles.
- ANOD lasts PHASE_CYC cycles. At the end of ANOD the pulse counter increments.
- After ANOD:
  - If pulses < N_PULSES: go to IPI.
  - Otherwise: assert `train_done` for one cycle, then go to REFR (macro on) or IDLE (macro off).
- IPI lasts IPI_CYC cycles, then returns to CATH.
- Abort is sampled every cycle and latched into `abort_pend`. It keeps charge balance:
  - In CATH/GAP/ANOD: complete the current ANOD, then end.
  - In IPI: end immediately on the next edge.
  - Ending via abort pulses `aborted` (not `train_done`) for one cycle and goes to REFR or IDLE as above.
  - Abort in IDLE/REFR is ignored and not latched.
- Abort and `train_done` coinciding on the last ANOD: `train_done` wins, `aborted` stays 0.
- `stim_amp` = latched amp in CATH/ANOD, 0 otherwise. An amp code of 0 still runs a full train.
- Reset values: state IDLE; all outputs 0; counters, `req_d`, latched amp and `abort_pend` all 0. Because `req_d` resets to 0, `stim_req` held high across reset release triggers on the first post-reset edge.
- Reset mid-train: outputs go to 0 on the reset edge; there is no completion of the pulse.

## Timing
- Trigger latency: `stim_req` rises before edge E; `stim_cath` is high from after edge E+1.
  - Edge E registers the trigger.
  - Edge E+1 enters CATH.
- Pulse period = 2·PHASE_CYC + GAP_CYC + IPI_CYC cycles.
- Train length = N_PULSES·(2·PHASE_CYC + GAP_CYC) + (N_PULSES−1)·IPI_CYC cycles.
- `train_done` is high in the first cycle after the last ANOD, i.e. in the first REFR or IDLE cycle.
- `stim_cath` and `stim_anod` are never high together. Between the phases there is at least 0 cycles of both low when GAP_CYC=0 (ANOD starts the cycle after CATH ends).
- `busy` rises with CATH entry and falls on IDLE entry.

## Configuration
- STIM_REFRACTORY_EN defined:
  - After train end (done or abort), stay in REFR for REFRACT_CYC cycles with `busy`=1 and triggers ignored, then go to IDLE.
  - A rising edge of `stim_req` during REFR is lost.
- Undefined:
  - REFR state and its counter are not built; the train returns straight to IDLE.
  - A rising edge of `stim_req` in the first IDLE cycle triggers a new train.

## Test plan
Use small parameters: PHASE_CYC=3, GAP_CYC=1, IPI_CYC=4, N_PULSES=2, REFRACT_CYC=10, `amp_in`=8'h5A.
- Single trigger: `stim_req` 0→1 held high.
  - Required pattern: cath 3 cycles, gap 1, anod 3, IPI 4, cath 3, gap 1, anod 3.
  - `stim_amp`=5A only during phases.
  - `train_done` 1 cycle after the final anod; no second train while `stim_req` stays high.
- GAP_CYC=0: `stim_anod` rises the cycle after `stim_cath` falls; the two are never overlapping.
- Abort during the first CATH: the first pulse completes (anod 3 cycles), `aborted`=1 once, no second pulse, `train_done` stays 0.
- Abort during IPI: next edge ends the train, `aborted` pulses, and `stim_cath` never rises again.
- Refractory:
  - Macro on: retrigger 5 cycles after `train_done` is ignored; retrigger 11 cycles after starts a train.
  - Macro off: retrigger 1 cycle after `train_done` starts a train.
- Reset in the middle of ANOD: all outputs are 0 after the reset edge. With `stim_req` held high through release, the train restarts with cath 2 edges after release.
